// File: rtl/ir_decode_fsm.sv
// ir_decode_fsm: MIPS-I instruction register and decoder with built-in
// FETCH / EXEC1 / EXEC2 sequencing.
// Optional feature macro: IR_DECODE_ILLEGAL_TRAP_EN.
// When defined, an illegal instruction in an unstalled EXEC1 halts the core.
// When undefined, an illegal instruction runs through the sequence as a NOP.
module ir_decode_fsm #(
   parameter int INSTR_W    = 32,
   parameter int REG_ADDR_W = 5,
   parameter int LINK_REG   = 31,
   parameter int IMM_OUT_W  = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [INSTR_W-1:0]    instr_in,
   input  logic                  instr_valid,
   input  logic                  stall,
   input  logic                  halt_req,
   output logic [1:0]            state,
   output logic [INSTR_W-1:0]    ir,
   output logic                  r_type,
   output logic                  i_type,
   output logic                  j_type,
   output logic [5:0]            opcode,
   output logic [REG_ADDR_W-1:0] rs,
   output logic [REG_ADDR_W-1:0] rt,
   output logic [REG_ADDR_W-1:0] dest_reg,
   output logic [4:0]            shamt,
   output logic [5:0]            function_code,
   output logic [IMM_OUT_W-1:0]  immediate,
   output logic [25:0]           target,
   output logic                  write_en,
   output logic                  illegal
);

   typedef enum logic [1:0] {
      ST_FETCH  = 2'b00,
      ST_EXEC1  = 2'b01,
      ST_EXEC2  = 2'b10,
      ST_HALTED = 2'b11
   } state_t;

   state_t               state_q, state_d;
   logic [INSTR_W-1:0]   ir_q, ir_d;

   logic [5:0]           op_s;
   logic [5:0]           func_s;
   logic [4:0]           rt_field_s;
   logic                 op_legal_s;
   logic                 func_legal_s;
   logic                 illegal_dec_s;
   logic                 cls_r_s;
   logic                 cls_j_s;
   logic                 cls_i_s;
   logic                 link_regimm_s;
   logic                 we_exec1_s;
   logic                 we_exec2_s;
   logic                 in_exec_s;

   assign op_s       = ir_q[31:26];
   assign func_s     = ir_q[5:0];
   assign rt_field_s = ir_q[20:16];

   // State and instruction register; reset aborts any instruction in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_FETCH;
         ir_q    <= {INSTR_W{1'b0}};
      end else begin
         state_q <= state_d;
         ir_q    <= ir_d;
      end
   end

   // Next-state logic; ir only loads on the FETCH->EXEC1 transition.
   always_comb begin
      state_d = state_q;
      ir_d    = ir_q;
      case (state_q)
         ST_FETCH: begin
            if (instr_valid && !stall) begin
               ir_d    = instr_in;
               state_d = ST_EXEC1;
            end else begin
               state_d = ST_FETCH;
            end
         end
         ST_EXEC1: begin
            if (stall) begin
               state_d = ST_EXEC1;
`ifdef IR_DECODE_ILLEGAL_TRAP_EN
            end else if (illegal_dec_s) begin
               state_d = ST_HALTED;
`endif
            end else begin
               state_d = ST_EXEC2;
            end
         end
         ST_EXEC2: begin
            if (stall) begin
               state_d = ST_EXEC2;
            end else if (halt_req) begin
               state_d = ST_HALTED;
            end else begin
               state_d = ST_FETCH;
            end
         end
         ST_HALTED: begin
            state_d = ST_HALTED;
         end
         default: begin
            state_d = ST_FETCH;
         end
      endcase
   end

   // Static decode of the held instruction: class, legality, write cycle.
   always_comb begin
      cls_r_s = 1'b0;
      cls_j_s = 1'b0;
      cls_i_s = 1'b0;
      if (op_s == 6'h00) begin
         cls_r_s = 1'b1;
      end else if ((op_s == 6'h02) || (op_s == 6'h03)) begin
         cls_j_s = 1'b1;
      end else begin
         cls_i_s = 1'b1;
      end

      case (op_s)
         6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07,
         6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F,
         6'h10, 6'h11, 6'h12, 6'h13,
         6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26,
         6'h28, 6'h29, 6'h2A, 6'h2B, 6'h2E,
         6'h30, 6'h31, 6'h32, 6'h33,
         6'h38, 6'h39, 6'h3A, 6'h3B: op_legal_s = 1'b1;
         default:                    op_legal_s = 1'b0;
      endcase

      case (func_s)
         6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
         6'h08, 6'h09, 6'h0C, 6'h0D,
         6'h10, 6'h11, 6'h12, 6'h13,
         6'h18, 6'h19, 6'h1A, 6'h1B,
         6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
         6'h2A, 6'h2B:               func_legal_s = 1'b1;
         default:                    func_legal_s = 1'b0;
      endcase

      illegal_dec_s = !op_legal_s || (cls_r_s && !func_legal_s);

      // BLTZAL / BGEZAL write the link register.
      link_regimm_s = (op_s == 6'h01) &&
                      ((rt_field_s == 5'b10000) || (rt_field_s == 5'b10001));

      // Results available in EXEC1: ALU R-type ops and ALU immediates.
      we_exec1_s = 1'b0;
      if (cls_r_s) begin
         case (func_s)
            6'h08, 6'h09, 6'h0C, 6'h0D, 6'h11, 6'h13,
            6'h18, 6'h19, 6'h1A, 6'h1B: we_exec1_s = 1'b0;
            default:                    we_exec1_s = 1'b1;
         endcase
      end else if ((op_s >= 6'h08) && (op_s <= 6'h0F)) begin
         we_exec1_s = 1'b1;
      end else begin
         we_exec1_s = 1'b0;
      end

      // Results available in EXEC2: link writes and loads.
      case (op_s)
         6'h00:   we_exec2_s = (func_s == 6'h09);
         6'h01:   we_exec2_s = link_regimm_s;
         6'h03, 6'h20, 6'h21, 6'h22, 6'h23,
         6'h24, 6'h25, 6'h26: we_exec2_s = 1'b1;
         default: we_exec2_s = 1'b0;
      endcase
   end

   // Output decode: fields gated by class, flags/enables only while executing.
   always_comb begin
      in_exec_s     = (state_q == ST_EXEC1) || (state_q == ST_EXEC2);
      r_type        = 1'b0;
      i_type        = 1'b0;
      j_type        = 1'b0;
      dest_reg      = {REG_ADDR_W{1'b0}};
      shamt         = 5'd0;
      function_code = 6'd0;
      immediate     = {IMM_OUT_W{1'b0}};
      target        = 26'd0;
      write_en      = 1'b0;
      illegal       = 1'b0;
      if (in_exec_s) begin
         r_type  = cls_r_s;
         i_type  = cls_i_s;
         j_type  = cls_j_s;
         illegal = illegal_dec_s;
         if (cls_r_s) begin
            dest_reg      = REG_ADDR_W'(ir_q[15:11]);
            shamt         = ir_q[10:6];
            function_code = func_s;
         end else if (cls_j_s) begin
            target   = ir_q[25:0];
            dest_reg = (op_s == 6'h03) ? REG_ADDR_W'(LINK_REG) : {REG_ADDR_W{1'b0}};
         end else begin
            dest_reg = link_regimm_s ? REG_ADDR_W'(LINK_REG) : REG_ADDR_W'(rt_field_s);
            case (op_s)
               6'h0C, 6'h0D, 6'h0E: immediate = IMM_OUT_W'(ir_q[15:0]);
               6'h0F:               immediate = IMM_OUT_W'({ir_q[15:0], 16'h0000});
               default:             immediate = IMM_OUT_W'(signed'(ir_q[15:0]));
            endcase
         end
         if (stall || illegal_dec_s) begin
            write_en = 1'b0;
         end else if (state_q == ST_EXEC1) begin
            write_en = we_exec1_s;
         end else begin
            write_en = we_exec2_s;
         end
      end else begin
         write_en = 1'b0;
      end
   end

   assign state  = state_q;
   assign ir     = ir_q;
   assign opcode = op_s;
   assign rs     = REG_ADDR_W'(ir_q[25:21]);
   assign rt     = REG_ADDR_W'(rt_field_s);

endmodule

// File: tb/tb_ir_decode_fsm.sv
// Directed testbench for ir_decode_fsm with hand-computed expected values.
module tb_ir_decode_fsm;

   logic        clk;
   logic        reset;
   logic [31:0] instr_in;
   logic        instr_valid;
   logic        stall;
   logic        halt_req;
   logic [1:0]  state;
   logic [31:0] ir;
   logic        r_type, i_type, j_type;
   logic [5:0]  opcode;
   logic [4:0]  rs, rt, dest_reg;
   logic [4:0]  shamt;
   logic [5:0]  function_code;
   logic [31:0] immediate;
   logic [25:0] target;
   logic        write_en;
   logic        illegal;

   int n_vec;
   int n_err;

   ir_decode_fsm dut (
      .clk(clk), .reset(reset), .instr_in(instr_in), .instr_valid(instr_valid),
      .stall(stall), .halt_req(halt_req), .state(state), .ir(ir),
      .r_type(r_type), .i_type(i_type), .j_type(j_type), .opcode(opcode),
      .rs(rs), .rt(rt), .dest_reg(dest_reg), .shamt(shamt),
      .function_code(function_code), .immediate(immediate), .target(target),
      .write_en(write_en), .illegal(illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Present an instruction for one FETCH edge; returns in EXEC1.
   task automatic load(input logic [31:0] w);
      instr_in    = w;
      instr_valid = 1'b1;
      cyc();
      instr_valid = 1'b0;
      instr_in    = 32'hDEAD_BEEF;
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      reset = 1'b1; instr_in = 32'h0; instr_valid = 1'b0; stall = 1'b0; halt_req = 1'b0;
      cyc(); cyc();
      reset = 1'b0;
      #1;
      check_val("rst_state", 32'(state), 32'd0);
      check_val("rst_ir", ir, 32'd0);
      check_val("rst_we", 32'(write_en), 32'd0);
      check_val("rst_rtype", 32'(r_type), 32'd0);
      check_val("rst_dest", 32'(dest_reg), 32'd0);

      // ADDU $3,$1,$2
      load(32'h0022_1821);
      check_val("addu_state1", 32'(state), 32'd1);
      check_val("addu_rtype", 32'(r_type), 32'd1);
      check_val("addu_dest", 32'(dest_reg), 32'd3);
      check_val("addu_func", 32'(function_code), 32'h21);
      check_val("addu_we1", 32'(write_en), 32'd1);
      check_val("addu_ir", ir, 32'h0022_1821);
      cyc();
      check_val("addu_state2", 32'(state), 32'd2);
      check_val("addu_we2", 32'(write_en), 32'd0);
      cyc();
      check_val("addu_fetch", 32'(state), 32'd0);

      // ORI: zero-extended; halt_req in EXEC1 must be ignored
      load(32'h3404_8000);
      check_val("ori_imm", immediate, 32'h0000_8000);
      check_val("ori_itype", 32'(i_type), 32'd1);
      check_val("ori_dest", 32'(dest_reg), 32'd4);
      check_val("ori_we1", 32'(write_en), 32'd1);
      halt_req = 1'b1;
      cyc();
      halt_req = 1'b0;
      check_val("ori_halt_ign", 32'(state), 32'd2);
      check_val("ori_we2", 32'(write_en), 32'd0);
      cyc();

      // ADDIU: sign-extended
      load(32'h2405_FFFF);
      check_val("addiu_imm", immediate, 32'hFFFF_FFFF);
      check_val("addiu_dest", 32'(dest_reg), 32'd5);
      cyc(); cyc();

      // LUI
      load(32'h3C01_ABCD);
      check_val("lui_imm", immediate, 32'hABCD_0000);
      cyc(); cyc();

      // JAL
      load(32'h0C00_0004);
      check_val("jal_jtype", 32'(j_type), 32'd1);
      check_val("jal_target", 32'(target), 32'h000_0004);
      check_val("jal_dest", 32'(dest_reg), 32'd31);
      check_val("jal_we1", 32'(write_en), 32'd0);
      cyc();
      check_val("jal_we2", 32'(write_en), 32'd1);
      cyc();

      // JR
      load(32'h03E0_0008);
      check_val("jr_we1", 32'(write_en), 32'd0);
      cyc();
      check_val("jr_we2", 32'(write_en), 32'd0);
      cyc();

      // BGEZAL
      load(32'h0431_0002);
      check_val("bgezal_dest", 32'(dest_reg), 32'd31);
      check_val("bgezal_imm", immediate, 32'h0000_0002);
      check_val("bgezal_we1", 32'(write_en), 32'd0);
      cyc();
      check_val("bgezal_we2", 32'(write_en), 32'd1);
      cyc();

      // LW with stall held over three edges in EXEC2
      load(32'h8C22_0004);
      check_val("lw_dest", 32'(dest_reg), 32'd2);
      check_val("lw_we1", 32'(write_en), 32'd0);
      cyc();
      stall    = 1'b1;
      instr_in = 32'h1234_5678;
      #1;
      for (int i = 0; i < 3; i++) begin
         check_val("lw_stall_state", 32'(state), 32'd2);
         check_val("lw_stall_we", 32'(write_en), 32'd0);
         check_val("lw_stall_ir", ir, 32'h8C22_0004);
         instr_in = ~instr_in;
         cyc();
      end
      stall = 1'b0;
      #1;
      check_val("lw_we2", 32'(write_en), 32'd1);
      check_val("lw_ir_hold", ir, 32'h8C22_0004);
      cyc();
      check_val("lw_fetch", 32'(state), 32'd0);

      // Halt in EXEC2, then reset out of HALTED
      load(32'h0022_1821);
      cyc();
      halt_req = 1'b1;
      cyc();
      halt_req = 1'b0;
      check_val("halt_state", 32'(state), 32'd3);
      instr_in    = 32'h3404_8000;
      instr_valid = 1'b1;
      cyc();
      instr_valid = 1'b0;
      check_val("halt_absorb", 32'(state), 32'd3);
      check_val("halt_we", 32'(write_en), 32'd0);
      check_val("halt_rtype", 32'(r_type), 32'd0);
      check_val("halt_ir", ir, 32'h0022_1821);
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      check_val("halt_rst_state", 32'(state), 32'd0);
      check_val("halt_rst_ir", ir, 32'd0);

      // Reset mid-EXEC1 aborts JAL before its EXEC2 write
      load(32'h0C00_0004);
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      check_val("abort_state", 32'(state), 32'd0);
      check_val("abort_we", 32'(write_en), 32'd0);
      cyc();
      check_val("abort_we_next", 32'(write_en), 32'd0);

      // Illegal opcode
      load(32'hFC00_0000);
      check_val("ill_flag", 32'(illegal), 32'd1);
      check_val("ill_we1", 32'(write_en), 32'd0);
      cyc();
`ifdef IR_DECODE_ILLEGAL_TRAP_EN
      check_val("ill_trap", 32'(state), 32'd3);
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      check_val("ill_rst", 32'(state), 32'd0);
`else
      check_val("ill_exec2", 32'(state), 32'd2);
      check_val("ill_we2", 32'(write_en), 32'd0);
      cyc();
      check_val("ill_fetch", 32'(state), 32'd0);
`endif

      // Illegal R-type function code
      load(32'h0000_0001);
      check_val("illf_flag", 32'(illegal), 32'd1);
      check_val("illf_we", 32'(write_en), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
